// File: rtl/phase_sequencer.sv
// N-phase frame sequencer: runs sub-block phases in order with an enable/done
// handshake, paces frames to a minimum period and traps a hung phase.
module phase_sequencer #(
  parameter int NUM_PHASES   = 3,
  parameter int TIMEOUT_W    = 16,
  parameter int TIMEOUT      = 1000,
  parameter int PERIOD_W     = 16,
  parameter int FRAME_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  abort_i,
  input  logic                  clr_i,
  input  logic [NUM_PHASES-1:0] done_i,
  output logic [NUM_PHASES-1:0] en_o,
  output logic [2:0]            phase_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  timeout_o,
  output logic [2:0]            err_phase_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_GAP,
    S_HOLD,
    S_ERROR
  } state_t;

  localparam logic [2:0]  LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [31:0] TIMEOUT_L  = 32'(TIMEOUT);
  localparam logic [31:0] PERIOD_L   = 32'(FRAME_PERIOD);

  state_t                  state_q, state_d;
  logic [2:0]              phase_d;
  logic [TIMEOUT_W-1:0]    wd_q, wd_d;
  logic [PERIOD_W-1:0]     timer_q, timer_d;
  logic [NUM_PHASES-1:0]   en_d;
  logic                    busy_d, fdone_d, tout_d;
  logic [15:0]             cnt_d;
  logic [2:0]              err_d;
  logic                    done_sel, wd_exp, hold_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_o      <= '0;
      wd_q         <= '0;
      timer_q      <= '0;
      en_o         <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      timeout_o    <= 1'b0;
      err_phase_o  <= '0;
    end else begin
      state_q      <= state_d;
      phase_o      <= phase_d;
      wd_q         <= wd_d;
      timer_q      <= timer_d;
      en_o         <= en_d;
      busy_o       <= busy_d;
      frame_done_o <= fdone_d;
      frame_cnt_o  <= cnt_d;
      timeout_o    <= tout_d;
      err_phase_o  <= err_d;
    end
  end

  // Timer + 1 >= period lets FRAME_PERIOD of 0 or 1 exit HOLD after one cycle.
  always_comb begin
    done_sel = 1'b0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (phase_o == 3'(k)) done_sel = done_i[k];
    end
    wd_exp  = (TIMEOUT != 0) && (32'(wd_q) == TIMEOUT_L - 32'd1);
    hold_ok = (32'(timer_q) + 32'd1) >= PERIOD_L;

    state_d = state_q;
    phase_d = phase_o;
    wd_d    = wd_q;
    timer_d = (&timer_q) ? timer_q : timer_q + PERIOD_W'(1);
    fdone_d = 1'b0;
    cnt_d   = frame_cnt_o;
    err_d   = err_phase_o;

    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_BUSY;
          phase_d = '0;
          wd_d    = '0;
          timer_d = '0;
        end
      end
      S_BUSY: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (done_sel) begin
          if (phase_o == LAST_PHASE) begin
            state_d = S_HOLD;
            fdone_d = 1'b1;
            cnt_d   = frame_cnt_o + 16'd1;
          end else begin
            state_d = S_GAP;
          end
        end else if (wd_exp) begin
          state_d = S_ERROR;
          err_d   = phase_o;
        end
      end
      S_GAP: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
          phase_d = phase_o + 3'd1;
          wd_d    = '0;
        end
      end
      S_HOLD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (hold_ok) begin
          if (run_i) begin
            state_d = S_BUSY;
            phase_d = '0;
            wd_d    = '0;
            timer_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERROR: begin
        if (clr_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    en_d = '0;
    if (state_d == S_BUSY) begin
      for (int k = 0; k < NUM_PHASES; k++) begin
        if (phase_d == 3'(k)) en_d[k] = 1'b1;
      end
    end
    busy_d = (state_d == S_BUSY);
    tout_d = (state_d == S_ERROR);
  end

endmodule
